dram1_ddr1_pad_rsp: RTL and testbench
=====================================

# dram1_ddr1_pad_rsp

- Pad-side responder model for one DDR channel.
- Receives the buffered controller command and write-data bus (`dram_io_*`, after the channel repeater) and returns read data on `io_dram_data_*` with DDR-style CAS and write latencies.
- Tracks per-bank open rows and stores written lines in a small internal array.
- Used as the far end of the channel in block- and chip-level simulation; synthesizable.

## Interface

Parameters:
- `CAS_LAT`, 3: cycles from RD sample to first read beat; legal 2..7.
- `WR_LAT`, 2: cycles from WR sample to first write-data beat; legal 1..6.
- `MEM_AW`, 6: array address width; 2^MEM_AW entries of 288 b; legal 5..10.

Ports:
- `clk` in 1: single clock, all logic rising-edge.
- `rst` in 1: synchronous, active-high reset.
- `dram_io_cs_l` in 4: chip selects, active-low; command valid when any bit is 0.
- `dram_io_ras_l`, `dram_io_cas_l`, `dram_io_write_en_l` in 1 each: command encoding.
- `dram_io_bank` in 3: bank.
- `dram_io_addr` in 15: row (ACT) / column (RD, WR); `addr[10]` = all-banks on PRE.
- `dram_io_data_out` in 288: write beat, `[287:256]` ECC, `[255:0]` data.
- `dram_io_drive_data` in 1: write beat qualifier.
- `dram_io_cke` in 1: clock enable.
- `dram_io_channel_disabled` in 1: channel off.
- `io_dram_data_valid` out 1: read beat valid.
- `io_dram_data_in` out 256: read data.
- `io_dram_ecc_in` out 32: read ECC.
- `rsp_err` out 1: one-cycle protocol-error pulse.
- `rsp_err_code` out 3: cause, valid with `rsp_err`.

## Operation

- Commands are decoded only when cs is active, `cke`=1 and `channel_disabled`=0. Otherwise the cycle is a NOP; in-flight bursts still complete.
- Command encoding, `{ras_l,cas_l,we_l}`:
  - 011 ACT
  - 101 RD
  - 100 WR
  - 010 PRE
  - 001 REF
  - 111 NOP
  - 000 MRS (ignored)
  - 110 ignored
- Bank table, 8 entries of {open, row[14:0]}:
  - ACT opens the bank and latches the row.
  - PRE closes `bank`, or all banks if `addr[10]`=1.
  - REF with any bank open: error, no state change.
- Burst length is fixed at 2 beats.
- Entry index = `{bank, addr[MEM_AW-4:1], beat}`.
- RD to an open bank schedules 2 read beats. Each beat drives the array entry; ECC comes from bits `[287:256]`.
- WR to an open bank schedules 2 write beats. A beat with `drive_data`=1 writes `dram_io_data_out` to its entry. A beat with `drive_data`=0 writes nothing and flags error.
- Array contents are undefined until written and are not reset.
- Error codes, each a 1-cycle `rsp_err` pulse; the offending command is dropped:
  - 1: ACT to an open bank
  - 2: RD/WR to a closed bank
  - 3: RD overlapping a scheduled read burst
  - 4: WR overlapping a scheduled write burst
  - 5: missing write beat
  - 6: REF with a bank open
- Errors in the same cycle are reported with priority to the lowest code.

## Timing

- RD sampled at edge t: `io_dram_data_valid`=1 during cycles t+CAS_LAT and t+CAS_LAT+1, beat 0 then beat 1. All read outputs are registered.
- RDs spaced exactly 2 cycles apart give gapless bursts. An RD 1 cycle after the previous one overlaps it and is an error (code 3).
- WR sampled at t: beats are sampled at edges t+WR_LAT and t+WR_LAT+1. The array is updated at that edge.
- A read beat to an entry being written in the same cycle returns the old contents.
- `io_dram_data_in` and `io_dram_ecc_in` are 0 whenever valid=0.
- Error pulse timing:
  - Command errors: `rsp_err` rises the cycle after the command.
  - Code 5: `rsp_err` rises the cycle after the missing beat.
- Reset values: `rst` sampled 1 at edge t clears, from cycle t+1:
  - all outputs to 0
  - the bank table to all closed
  - the read and write pipelines to empty
- A burst interrupted by reset is abandoned, not resumed.

## Structure

- Package `dram_rsp_pkg` holds:
  - the command enum (ACT/RD/WR/PRE/REF/NOP/MRS)
  - the error-code localparams
  - the burst-length constant (2)
  - the data/ECC width constants 256/32
- Sub-module `dram1_ddr1_rsp_bank_tbl`: the 8-entry open/row table, with open/close/close-all ports and an open-status lookup.
- Read and write schedules are shift registers of {valid, index} of depth CAS_LAT+1 and WR_LAT+1, in the top level.

## Test plan

- **Write then read:** ACT b2 row 0x10; WR b2 col 0x4 with beats A/B; RD b2 col 0x4 at cycle t → valid at t+3 and t+4 with data A then B, ECC matching bits `[287:256]`.
- **Read to closed bank:** RD to closed b5 → no valid, `rsp_err`=1 with code 2 next cycle.
- **Back-to-back reads:** RDs at t and t+2 → valid continuous for t+3..t+6. RDs at t and t+1 → second dropped, code 3.
- **Precharge-all and ACT conflict:** PRE with `addr[10]`=1 closes all banks, so a following RD gives code 2. ACT to an already-open bank gives code 1.
- **Gated commands:** WR with `drive_data` low on beat 1 → only beat 0 written, code 5. Commands with `cke`=0 or `channel_disabled`=1 → no effect, no error.
- **Reset mid-burst:** `rst` during a read burst → valid=0 and data=0 the next cycle, all banks closed, so a subsequent RD gives code 2.

Source files
------------

// File: rtl/dram_rsp_pkg.sv
// dram_rsp_pkg
// Shared definitions for the DDR pad-side responder model:
//   - cmd_e      : decoded DDR command, encoded as {ras_l, cas_l, we_l}
//   - ERR_*      : protocol error codes reported on rsp_err_code
//   - BURST_LEN  : fixed burst length in beats
//   - DATA_W / ECC_W / LINE_W : read/write line geometry
//   - decode_cmd : maps the raw command pins onto cmd_e
package dram_rsp_pkg;

    localparam int BURST_LEN = 2;
    localparam int DATA_W    = 256;
    localparam int ECC_W     = 32;
    localparam int LINE_W    = DATA_W + ECC_W;
    localparam int NUM_BANKS = 8;
    localparam int ROW_W     = 15;

    typedef enum logic [2:0] {
        CMD_MRS = 3'b000,
        CMD_REF = 3'b001,
        CMD_PRE = 3'b010,
        CMD_ACT = 3'b011,
        CMD_WR  = 3'b100,
        CMD_RD  = 3'b101,
        CMD_NOP = 3'b111
    } cmd_e;

    localparam logic [2:0] ERR_NONE        = 3'd0;
    localparam logic [2:0] ERR_ACT_OPEN    = 3'd1;
    localparam logic [2:0] ERR_BANK_CLOSED = 3'd2;
    localparam logic [2:0] ERR_RD_OVERLAP  = 3'd3;
    localparam logic [2:0] ERR_WR_OVERLAP  = 3'd4;
    localparam logic [2:0] ERR_WR_BEAT     = 3'd5;
    localparam logic [2:0] ERR_REF_OPEN    = 3'd6;

    // The unused 3'b110 encoding is folded into NOP so it has no effect.
    function automatic cmd_e decode_cmd(input logic ras_l, input logic cas_l,
                                        input logic we_l);
        cmd_e c;
        case ({ras_l, cas_l, we_l})
            3'b011:  c = CMD_ACT;
            3'b101:  c = CMD_RD;
            3'b100:  c = CMD_WR;
            3'b010:  c = CMD_PRE;
            3'b001:  c = CMD_REF;
            3'b000:  c = CMD_MRS;
            default: c = CMD_NOP;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/dram1_ddr1_rsp_bank_tbl.sv
// dram1_ddr1_rsp_bank_tbl
// Eight-entry bank table holding {open, row} per bank.
// Ports:
//   clk, rst      : clock, synchronous active-high reset (all banks closed)
//   open_en       : open open_bank and latch open_row
//   close_en      : close close_bank, or every bank when close_all is set
//   lookup_bank   : bank being queried this cycle
//   lookup_open   : 1 when lookup_bank is open
//   lookup_row    : row latched for lookup_bank
//   any_open      : 1 when at least one bank is open
module dram1_ddr1_rsp_bank_tbl
    import dram_rsp_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             open_en,
    input  logic [2:0]       open_bank,
    input  logic [ROW_W-1:0] open_row,
    input  logic             close_en,
    input  logic [2:0]       close_bank,
    input  logic             close_all,
    input  logic [2:0]       lookup_bank,
    output logic             lookup_open,
    output logic [ROW_W-1:0] lookup_row,
    output logic             any_open
);

    logic [NUM_BANKS-1:0] open_q;
    logic [ROW_W-1:0]     row_q [NUM_BANKS];

    always_ff @(posedge clk) begin
        if (rst) begin
            open_q <= '0;
            for (int i = 0; i < NUM_BANKS; i++) begin
                row_q[i] <= '0;
            end
        end else begin
            if (close_en) begin
                if (close_all) begin
                    open_q <= '0;
                end else begin
                    open_q[close_bank] <= 1'b0;
                end
            end
            if (open_en) begin
                open_q[open_bank] <= 1'b1;
                row_q[open_bank]  <= open_row;
            end
        end
    end

    assign lookup_open = open_q[lookup_bank];
    assign lookup_row  = row_q[lookup_bank];
    assign any_open    = |open_q;

endmodule

// File: rtl/dram1_ddr1_pad_rsp.sv
// dram1_ddr1_pad_rsp
// Pad-side responder model for one DDR channel. Decodes the buffered
// controller command bus, tracks open banks, stores written lines in an
// internal array and returns read bursts after CAS_LAT cycles.
// Ports:
//   clk, rst                  : clock, synchronous active-high reset
//   dram_io_cs_l/ras_l/cas_l/write_en_l : command pins (active-low)
//   dram_io_bank, dram_io_addr          : bank and row/column address
//   dram_io_data_out, dram_io_drive_data: write beat and its qualifier
//   dram_io_cke, dram_io_channel_disabled : command gating
//   io_dram_data_valid/data_in/ecc_in   : registered read beat
//   rsp_err, rsp_err_code               : one-cycle protocol error pulse
module dram1_ddr1_pad_rsp
    import dram_rsp_pkg::*;
#(
    parameter int CAS_LAT = 3,
    parameter int WR_LAT  = 2,
    parameter int MEM_AW  = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        dram_io_cs_l,
    input  logic              dram_io_ras_l,
    input  logic              dram_io_cas_l,
    input  logic              dram_io_write_en_l,
    input  logic [2:0]        dram_io_bank,
    input  logic [14:0]       dram_io_addr,
    input  logic [LINE_W-1:0] dram_io_data_out,
    input  logic              dram_io_drive_data,
    input  logic              dram_io_cke,
    input  logic              dram_io_channel_disabled,
    output logic              io_dram_data_valid,
    output logic [DATA_W-1:0] io_dram_data_in,
    output logic [ECC_W-1:0]  io_dram_ecc_in,
    output logic              rsp_err,
    output logic [2:0]        rsp_err_code
);

    localparam int DEPTH = 1 << MEM_AW;

    logic              cmd_en;
    cmd_e              cmd;
    logic              bank_open;
    logic              any_open;
    logic [ROW_W-1:0]  unused_open_row;
    logic [MEM_AW-2:0] cmd_line;
    logic              rd_accept;
    logic              wr_accept;
    logic [CAS_LAT:0]  rd_vld;
    logic [MEM_AW-1:0] rd_idx [CAS_LAT+1];
    logic [WR_LAT:0]   wr_vld;
    logic [MEM_AW-1:0] wr_idx [WR_LAT+1];
    logic              wr_beat_fire;
    logic [6:1]        err_hit;
    logic [2:0]        err_code_nxt;
    logic [LINE_W-1:0] rd_line;
    logic [LINE_W-1:0] mem [DEPTH];

    assign cmd_en = (dram_io_cs_l != 4'hF) && dram_io_cke && !dram_io_channel_disabled;

    always_comb begin
        cmd = CMD_NOP;
        if (cmd_en) begin
            cmd = decode_cmd(dram_io_ras_l, dram_io_cas_l, dram_io_write_en_l);
        end
    end

    // Line address of a burst; the beat number supplies the index LSB.
    assign cmd_line = {dram_io_bank, dram_io_addr[MEM_AW-4:1]};

    dram1_ddr1_rsp_bank_tbl u_bank_tbl (
        .clk         (clk),
        .rst         (rst),
        .open_en     ((cmd == CMD_ACT) && !bank_open),
        .open_bank   (dram_io_bank),
        .open_row    (dram_io_addr),
        .close_en    (cmd == CMD_PRE),
        .close_bank  (dram_io_bank),
        .close_all   (dram_io_addr[10]),
        .lookup_bank (dram_io_bank),
        .lookup_open (bank_open),
        .lookup_row  (unused_open_row),
        .any_open    (any_open)
    );

    // A burst loads stage 1 with beat 0 and stage 0 with beat 1, so stage 0
    // being occupied means the previous burst was accepted one cycle ago and
    // a new burst would collide with it.
    assign rd_accept = (cmd == CMD_RD) && bank_open && !rd_vld[0];
    assign wr_accept = (cmd == CMD_WR) && bank_open && !wr_vld[0];

    always_comb begin
        err_hit                  = '0;
        err_hit[ERR_ACT_OPEN]    = (cmd == CMD_ACT) && bank_open;
        err_hit[ERR_BANK_CLOSED] = ((cmd == CMD_RD) || (cmd == CMD_WR)) && !bank_open;
        err_hit[ERR_RD_OVERLAP]  = (cmd == CMD_RD) && bank_open && rd_vld[0];
        err_hit[ERR_WR_OVERLAP]  = (cmd == CMD_WR) && bank_open && wr_vld[0];
        err_hit[ERR_WR_BEAT]     = wr_vld[WR_LAT] && !dram_io_drive_data;
        err_hit[ERR_REF_OPEN]    = (cmd == CMD_REF) && any_open;
    end

    // Scanning downwards leaves the lowest active code as the reported one.
    always_comb begin
        err_code_nxt = ERR_NONE;
        for (int c = 6; c >= 1; c--) begin
            if (err_hit[c]) begin
                err_code_nxt = 3'(c);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_vld <= '0;
            wr_vld <= '0;
        end else begin
            rd_vld <= {rd_vld[CAS_LAT-1:0], 1'b0};
            wr_vld <= {wr_vld[WR_LAT-1:0], 1'b0};
            if (rd_accept) begin
                rd_vld[BURST_LEN-1:0] <= '1;
            end
            if (wr_accept) begin
                wr_vld[BURST_LEN-1:0] <= '1;
            end
        end
    end

    // Index stages only matter where the matching valid bit is set.
    always_ff @(posedge clk) begin
        for (int i = CAS_LAT; i > 0; i--) begin
            rd_idx[i] <= rd_idx[i-1];
        end
        for (int i = WR_LAT; i > 0; i--) begin
            wr_idx[i] <= wr_idx[i-1];
        end
        if (rd_accept) begin
            rd_idx[1] <= {cmd_line, 1'b0};
            rd_idx[0] <= {cmd_line, 1'b1};
        end
        if (wr_accept) begin
            wr_idx[1] <= {cmd_line, 1'b0};
            wr_idx[0] <= {cmd_line, 1'b1};
        end
    end

    // A write beat due on a reset edge belongs to an abandoned burst.
    assign wr_beat_fire = wr_vld[WR_LAT] && dram_io_drive_data && !rst;

    always_ff @(posedge clk) begin
        if (wr_beat_fire) begin
            mem[wr_idx[WR_LAT]] <= dram_io_data_out;
        end
    end

    // Reading before the same-edge write lands returns the old contents.
    assign rd_line = mem[rd_idx[CAS_LAT]];

    always_ff @(posedge clk) begin
        if (rst) begin
            io_dram_data_valid <= 1'b0;
            io_dram_data_in    <= '0;
            io_dram_ecc_in     <= '0;
        end else if (rd_vld[CAS_LAT]) begin
            io_dram_data_valid <= 1'b1;
            io_dram_data_in    <= rd_line[DATA_W-1:0];
            io_dram_ecc_in     <= rd_line[LINE_W-1:DATA_W];
        end else begin
            io_dram_data_valid <= 1'b0;
            io_dram_data_in    <= '0;
            io_dram_ecc_in     <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_err      <= 1'b0;
            rsp_err_code <= ERR_NONE;
        end else begin
            rsp_err      <= |err_hit;
            rsp_err_code <= err_code_nxt;
        end
    end

endmodule

// File: tb/tb_dram1_ddr1_pad_rsp.sv
// tb_dram1_ddr1_pad_rsp
// Directed bench for dram1_ddr1_pad_rsp. Stimulus pushes expected read beats
// and error pulses (tagged with the cycle they must appear in) into queues;
// a negedge monitor pops and compares whenever the DUT presents an output.
module tb_dram1_ddr1_pad_rsp;

    localparam int CAS_LAT = 3;
    localparam int WR_LAT  = 2;
    localparam int MEM_AW  = 6;

    localparam logic [2:0] C_ACT = 3'b011;
    localparam logic [2:0] C_RD  = 3'b101;
    localparam logic [2:0] C_WR  = 3'b100;
    localparam logic [2:0] C_PRE = 3'b010;
    localparam logic [2:0] C_REF = 3'b001;

    localparam logic [287:0] LA = {32'hECC0_000A, {8{32'hA5A5_0001}}};
    localparam logic [287:0] LB = {32'hECC0_000B, {8{32'hB6B6_0002}}};
    localparam logic [287:0] LC = {32'hECC0_000C, {8{32'hC7C7_0003}}};
    localparam logic [287:0] LD = {32'hECC0_000D, {8{32'hD8D8_0004}}};
    localparam logic [287:0] LE = {32'hECC0_000E, {8{32'hE9E9_0005}}};
    localparam logic [287:0] LP = {32'hECC0_0010, {8{32'h1212_0006}}};
    localparam logic [287:0] LQ = {32'hECC0_0011, {8{32'h3434_0007}}};

    typedef struct {
        int             cyc;
        logic [287:0]   line;
    } rd_exp_t;

    typedef struct {
        int             cyc;
        logic [2:0]     code;
    } err_exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   dram_io_cs_l;
    logic         dram_io_ras_l;
    logic         dram_io_cas_l;
    logic         dram_io_write_en_l;
    logic [2:0]   dram_io_bank;
    logic [14:0]  dram_io_addr;
    logic [287:0] dram_io_data_out;
    logic         dram_io_drive_data;
    logic         dram_io_cke;
    logic         dram_io_channel_disabled;
    logic         io_dram_data_valid;
    logic [255:0] io_dram_data_in;
    logic [31:0]  io_dram_ecc_in;
    logic         rsp_err;
    logic [2:0]   rsp_err_code;

    int       cyc = 0;
    int       tests = 0;
    int       fails = 0;
    logic     chk_en = 1'b0;
    rd_exp_t  rd_q[$];
    err_exp_t err_q[$];
    rd_exp_t  mon_rd;
    err_exp_t mon_err;

    dram1_ddr1_pad_rsp #(
        .CAS_LAT (CAS_LAT),
        .WR_LAT  (WR_LAT),
        .MEM_AW  (MEM_AW)
    ) dut (
        .clk                      (clk),
        .rst                      (rst),
        .dram_io_cs_l             (dram_io_cs_l),
        .dram_io_ras_l            (dram_io_ras_l),
        .dram_io_cas_l            (dram_io_cas_l),
        .dram_io_write_en_l       (dram_io_write_en_l),
        .dram_io_bank             (dram_io_bank),
        .dram_io_addr             (dram_io_addr),
        .dram_io_data_out         (dram_io_data_out),
        .dram_io_drive_data       (dram_io_drive_data),
        .dram_io_cke              (dram_io_cke),
        .dram_io_channel_disabled (dram_io_channel_disabled),
        .io_dram_data_valid       (io_dram_data_valid),
        .io_dram_data_in          (io_dram_data_in),
        .io_dram_ecc_in           (io_dram_ecc_in),
        .rsp_err                  (rsp_err),
        .rsp_err_code             (rsp_err_code)
    );

    always #5 clk = ~clk;

    // After edge e the counter reads e, so a command driven now is sampled
    // at edge cyc+1.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [287:0] actual,
                               input logic [287:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %h, want %h", name, actual, expected);
        end
    endtask

    // Drives one command for exactly one clock; t is the sampling edge.
    task automatic applyStimulus(input logic [3:0] cs_l, input logic [2:0] cmd_bits,
                                 input logic [2:0] bank, input logic [14:0] addr,
                                 output int t);
        t = cyc + 1;
        dram_io_cs_l = cs_l;
        {dram_io_ras_l, dram_io_cas_l, dram_io_write_en_l} = cmd_bits;
        dram_io_bank = bank;
        dram_io_addr = addr;
        @(negedge clk);
        dram_io_cs_l = 4'hF;
        {dram_io_ras_l, dram_io_cas_l, dram_io_write_en_l} = 3'b111;
    endtask

    task automatic expect_read(input int t, input logic [287:0] b0, input logic [287:0] b1);
        rd_q.push_back('{cyc: t + CAS_LAT, line: b0});
        rd_q.push_back('{cyc: t + CAS_LAT + 1, line: b1});
    endtask

    task automatic expect_err(input int t, input logic [2:0] code);
        err_q.push_back('{cyc: t, code: code});
    endtask

    task automatic write_burst(input logic [2:0] bank, input logic [14:0] addr,
                               input logic [287:0] b0, input logic [287:0] b1,
                               input logic drive1);
        int t;
        applyStimulus(4'b1110, C_WR, bank, addr, t);
        if (!drive1) expect_err(t + WR_LAT + 1, 3'd5);
        repeat (WR_LAT - 1) @(negedge clk);
        dram_io_data_out   = b0;
        dram_io_drive_data = 1'b1;
        @(negedge clk);
        dram_io_data_out   = b1;
        dram_io_drive_data = drive1;
        @(negedge clk);
        dram_io_data_out   = '0;
        dram_io_drive_data = 1'b0;
    endtask

    // Scoreboard monitor: overdue expectations are misses, outputs with no
    // expectation are spurious.
    always @(negedge clk) begin
        if (chk_en) begin
            while (rd_q.size() > 0 && rd_q[0].cyc < cyc) begin
                tests++;
                fails++;
                $display("[TB] FAIL read_missing: beat due cycle %0d not seen, now cycle %0d",
                         rd_q[0].cyc, cyc);
                rd_q.delete(0);
            end
            while (err_q.size() > 0 && err_q[0].cyc < cyc) begin
                tests++;
                fails++;
                $display("[TB] FAIL err_missing: code %0d due cycle %0d not seen, now cycle %0d",
                         err_q[0].code, err_q[0].cyc, cyc);
                err_q.delete(0);
            end
            tests++;
            if (io_dram_data_valid) begin
                if (rd_q.size() == 0) begin
                    fails++;
                    $display("[TB] FAIL read_spurious: valid at cycle %0d, data %h, want no beat",
                             cyc, {io_dram_ecc_in, io_dram_data_in});
                end else begin
                    mon_rd = rd_q.pop_front();
                    if (mon_rd.cyc != cyc || {io_dram_ecc_in, io_dram_data_in} !== mon_rd.line) begin
                        fails++;
                        $display("[TB] FAIL read_beat: got cycle %0d data %h, want cycle %0d data %h",
                                 cyc, {io_dram_ecc_in, io_dram_data_in}, mon_rd.cyc, mon_rd.line);
                    end
                end
            end else if (io_dram_data_in !== '0 || io_dram_ecc_in !== '0) begin
                fails++;
                $display("[TB] FAIL idle_zero: cycle %0d got data %h, want 0",
                         cyc, {io_dram_ecc_in, io_dram_data_in});
            end
            if (rsp_err) begin
                tests++;
                if (err_q.size() == 0) begin
                    fails++;
                    $display("[TB] FAIL err_spurious: code %0d at cycle %0d, want no error",
                             rsp_err_code, cyc);
                end else begin
                    mon_err = err_q.pop_front();
                    if (mon_err.cyc != cyc || rsp_err_code !== mon_err.code) begin
                        fails++;
                        $display("[TB] FAIL err_pulse: got code %0d at cycle %0d, want code %0d at cycle %0d",
                                 rsp_err_code, cyc, mon_err.code, mon_err.cyc);
                    end
                end
            end
        end
    end

    initial begin
        int t;
        int t2;
        rst                      = 1'b1;
        dram_io_cs_l             = 4'hF;
        dram_io_ras_l            = 1'b1;
        dram_io_cas_l            = 1'b1;
        dram_io_write_en_l       = 1'b1;
        dram_io_bank             = '0;
        dram_io_addr             = '0;
        dram_io_data_out         = '0;
        dram_io_drive_data       = 1'b0;
        dram_io_cke              = 1'b1;
        dram_io_channel_disabled = 1'b0;

        repeat (3) @(negedge clk);
        checkOutput("reset_valid", {287'd0, io_dram_data_valid}, 288'd0);
        checkOutput("reset_data", {io_dram_ecc_in, io_dram_data_in}, 288'd0);
        checkOutput("reset_err", {287'd0, rsp_err}, 288'd0);
        checkOutput("reset_code", {285'd0, rsp_err_code}, 288'd0);
        rst    = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);

        // Write then read back through bank 2.
        applyStimulus(4'b1110, C_ACT, 3'd2, 15'h0010, t);
        write_burst(3'd2, 15'h0004, LA, LB, 1'b1);
        write_burst(3'd2, 15'h0002, LP, LQ, 1'b1);
        repeat (2) @(negedge clk);
        applyStimulus(4'b1110, C_RD, 3'd2, 15'h0004, t);
        expect_read(t, LA, LB);
        repeat (6) @(negedge clk);

        // Read to a closed bank.
        applyStimulus(4'b1110, C_RD, 3'd5, 15'h0004, t);
        expect_err(t, 3'd2);
        repeat (3) @(negedge clk);

        // Reads two cycles apart stream without a gap.
        applyStimulus(4'b1110, C_RD, 3'd2, 15'h0004, t);
        expect_read(t, LA, LB);
        @(negedge clk);
        applyStimulus(4'b1110, C_RD, 3'd2, 15'h0002, t2);
        expect_read(t2, LP, LQ);
        repeat (6) @(negedge clk);

        // Reads one cycle apart: the second is dropped.
        applyStimulus(4'b1110, C_RD, 3'd2, 15'h0004, t);
        expect_read(t, LA, LB);
        applyStimulus(4'b1110, C_RD, 3'd2, 15'h0002, t2);
        expect_err(t2, 3'd3);
        repeat (6) @(negedge clk);

        // Writes one cycle apart: the second is dropped and needs no beats.
        applyStimulus(4'b1110, C_WR, 3'd2, 15'h0000, t);
        applyStimulus(4'b1110, C_WR, 3'd2, 15'h0000, t2);
        expect_err(t2, 3'd4);
        repeat (WR_LAT - 2) @(negedge clk);
        dram_io_data_out   = LC;
        dram_io_drive_data = 1'b1;
        @(negedge clk);
        dram_io_data_out   = LD;
        @(negedge clk);
        dram_io_data_out   = '0;
        dram_io_drive_data = 1'b0;
        repeat (3) @(negedge clk);
        applyStimulus(4'b1110, C_RD, 3'd2, 15'h0000, t);
        expect_read(t, LC, LD);
        repeat (6) @(negedge clk);

        // Missing second write beat: only beat 0 lands.
        write_burst(3'd2, 15'h0002, LE, LB, 1'b0);
        repeat (3) @(negedge clk);
        applyStimulus(4'b1110, C_RD, 3'd2, 15'h0002, t);
        expect_read(t, LE, LQ);
        repeat (6) @(negedge clk);

        // Gated commands have no effect and raise no error.
        dram_io_cke = 1'b0;
        applyStimulus(4'b1110, C_PRE, 3'd0, 15'h0400, t);
        dram_io_cke = 1'b1;
        dram_io_channel_disabled = 1'b1;
        applyStimulus(4'b1110, C_ACT, 3'd2, 15'h0010, t);
        dram_io_channel_disabled = 1'b0;
        applyStimulus(4'b1111, C_RD, 3'd5, 15'h0004, t);
        applyStimulus(4'b1101, C_RD, 3'd2, 15'h0004, t);
        expect_read(t, LA, LB);
        repeat (6) @(negedge clk);

        // ACT conflict, single-bank and all-bank precharge, refresh checks.
        applyStimulus(4'b1110, C_ACT, 3'd2, 15'h0010, t);
        expect_err(t, 3'd1);
        applyStimulus(4'b1110, C_ACT, 3'd3, 15'h0001, t);
        applyStimulus(4'b1110, C_PRE, 3'd3, 15'h0000, t);
        applyStimulus(4'b1110, C_RD, 3'd3, 15'h0004, t);
        expect_err(t, 3'd2);
        applyStimulus(4'b1110, C_REF, 3'd0, 15'h0000, t);
        expect_err(t, 3'd6);
        applyStimulus(4'b1110, C_PRE, 3'd0, 15'h0400, t);
        applyStimulus(4'b1110, C_RD, 3'd2, 15'h0004, t);
        expect_err(t, 3'd2);
        applyStimulus(4'b1110, C_REF, 3'd0, 15'h0000, t);
        repeat (4) @(negedge clk);

        // Reset during a read burst abandons beat 1 and closes all banks.
        applyStimulus(4'b1110, C_ACT, 3'd2, 15'h0010, t);
        applyStimulus(4'b1110, C_RD, 3'd2, 15'h0004, t);
        rd_q.push_back('{cyc: t + CAS_LAT, line: LA});
        repeat (CAS_LAT) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("rst_mid_valid", {287'd0, io_dram_data_valid}, 288'd0);
        checkOutput("rst_mid_data", {io_dram_ecc_in, io_dram_data_in}, 288'd0);
        rst = 1'b0;
        applyStimulus(4'b1110, C_RD, 3'd2, 15'h0004, t);
        expect_err(t, 3'd2);
        repeat (8) @(negedge clk);

        checkOutput("read_queue_empty", 288'(rd_q.size()), 288'd0);
        checkOutput("err_queue_empty", 288'(err_q.size()), 288'd0);
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
